// File: rtl/cfg_mux_pkg.sv
// cfg_mux_pkg: definitions shared by the cfg_mux_bank slice.
//   state_t : configuration FSM states (IDLE, LOAD, COMMIT)
//   clog2   : ceiling log2 helper for sizing select/index fields
package cfg_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cfg_mux_chan.sv
// cfg_mux_chan: one routing-mux channel, purely combinational.
// Ports:
//   in  [N_IN]  channel inputs
//   sel [SEL_W] input select
//   out         in[sel]
module cfg_mux_chan
  import cfg_mux_pkg::*;
#(
  parameter  int N_IN  = 16,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  // N_IN is a power of two, so every sel value addresses a real input.
  always_comb out = in[sel];

endmodule

// File: rtl/cfg_mux_bank.sv
// cfg_mux_bank: bank of N_CH routing muxes with double-buffered selects.
// Config frames are loaded one select per word into shadow registers and
// copied to the active registers in a single COMMIT cycle.
// Ports:
//   CLK, RST             clock, async active-high reset
//   cfg_start            opens a config frame (pulse)
//   cfg_valid/cfg_ready  config word handshake
//   cfg_data  [SEL_W]    select for channel at the write pointer
//   cfg_done             one-cycle pulse during COMMIT
//   cfg_err              sticky protocol-error flag (cleared by reset only)
//   mux_in  [N_CH*N_IN]  channel c input i at bit c*N_IN+i
//   mux_out [N_CH]       channel outputs
// Optional: define CFG_MUX_BANK_READBACK_EN to add rb_idx/rb_sel, a
// registered readback of active_sel[rb_idx].
module cfg_mux_bank
  import cfg_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int N_IN  = 16,
  localparam int SEL_W = clog2(N_IN),
  localparam int IDX_W = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [SEL_W-1:0]     cfg_data,
  output logic                 cfg_done,
  output logic                 cfg_err,
  input  logic [N_CH*N_IN-1:0] mux_in,
  output logic [N_CH-1:0]      mux_out
`ifdef CFG_MUX_BANK_READBACK_EN
  ,
  input  logic [IDX_W-1:0]     rb_idx,
  output logic [SEL_W-1:0]     rb_sel
`endif
);

  state_t           state, state_next;
  logic [IDX_W-1:0] wptr;
  logic [SEL_W-1:0] shadow_sel [N_CH];
  logic [SEL_W-1:0] active_sel [N_CH];
  logic             accept, ptr_clr, err_set;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    accept     = 1'b0;
    ptr_clr    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        // A start with a simultaneous valid only opens the frame.
        if (cfg_start) begin
          state_next = LOAD;
          ptr_clr    = 1'b1;
        end else if (cfg_valid) begin
          err_set = 1'b1;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        // Restart wins over a word presented in the same cycle.
        if (cfg_start) begin
          ptr_clr = 1'b1;
          err_set = 1'b1;
        end else if (cfg_valid) begin
          accept = 1'b1;
          if (wptr == IDX_W'(N_CH - 1)) state_next = COMMIT;
        end
      end
      COMMIT: begin
        cfg_done   = 1'b1;
        err_set    = cfg_start;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr    <= '0;
      cfg_err <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        shadow_sel[c] <= '0;
        active_sel[c] <= '0;
      end
    end else begin
      if (ptr_clr)     wptr <= '0;
      else if (accept) wptr <= wptr + IDX_W'(1);
      if (accept) shadow_sel[wptr] <= cfg_data;
      if (state == COMMIT) begin
        for (int unsigned c = 0; c < N_CH; c++) active_sel[c] <= shadow_sel[c];
      end
      if (err_set) cfg_err <= 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    cfg_mux_chan #(.N_IN(N_IN)) u_chan (
      .in  (mux_in[c*N_IN +: N_IN]),
      .sel (active_sel[c]),
      .out (mux_out[c])
    );
  end

`ifdef CFG_MUX_BANK_READBACK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      rb_sel <= '0;
    else if (int'(rb_idx) < N_CH) rb_sel <= active_sel[rb_idx];
    else                          rb_sel <= '0;
  end
`endif

endmodule

// File: tb/tb_cfg_mux_bank.sv
// tb_cfg_mux_bank: self-checking bench for cfg_mux_bank (default build,
// N_CH=8, N_IN=16). Directed frames plus randomized traffic, compared
// against a frame-level reference model.
module tb_cfg_mux_bank;

  localparam int N_CH = 8;
  localparam int N_IN = 16;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 cfg_start, cfg_valid;
  logic                 cfg_ready, cfg_done, cfg_err;
  logic [3:0]           cfg_data;
  logic [N_CH*N_IN-1:0] mux_in;
  logic [N_CH-1:0]      mux_out;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 loading, 2 committing.
  int phase;
  int cnt;
  int frame_m [N_CH];
  int act_m   [N_CH];
  bit err_m;

  cfg_mux_bank #(.N_CH(N_CH), .N_IN(N_IN)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .mux_in    (mux_in),
    .mux_out   (mux_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_CH-1:0] route_all(input int sel);
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = mux_in[c*N_IN + sel];
    return r;
  endfunction

  function automatic logic [N_CH-1:0] route_model();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = mux_in[c*N_IN + act_m[c]];
    return r;
  endfunction

  task automatic model_reset();
    phase = 0;
    cnt   = 0;
    err_m = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      frame_m[c] = 0;
      act_m[c]   = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit v, input int d);
    case (phase)
      0: if (s) begin phase = 1; cnt = 0; end
         else if (v) err_m = 1'b1;
      1: if (s) begin cnt = 0; err_m = 1'b1; end
         else if (v) begin
           frame_m[cnt] = d;
           if (cnt == N_CH - 1) phase = 2;
           cnt++;
         end
      default: begin
        for (int c = 0; c < N_CH; c++) act_m[c] = frame_m[c];
        if (s) err_m = 1'b1;
        phase = 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, 32'(cfg_ready), 32'(phase == 1));
    check({tag, ".done"},  32'(cfg_done),  32'(phase == 2));
    check({tag, ".err"},   32'(cfg_err),   32'(err_m));
    check({tag, ".mux"},   32'(mux_out),   32'(route_model()));
  endtask

  task automatic rand_mux();
    mux_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycle(input string tag, input bit s, input bit v, input int d);
    cfg_start = s;
    cfg_valid = v;
    cfg_data  = 4'(d);
    rand_mux();
    #1;
    check_all(tag);
    model_edge(s, v, d);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    mux_in    = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int c = 0; c < N_CH; c++) mux_in[c*N_IN] = 1'b1;
    #1;
    check("rst_in0", 32'(mux_out), 32'hFF);
    @(posedge CLK);
    #1;

    // Back-to-back frame 0..7.
    cycle("f1_start", 1, 0, 0);
    for (int i = 0; i < N_CH; i++) cycle("f1_word", 0, 1, i);
    cycle("f1_commit", 0, 0, 0);
    cycle("f1_after", 0, 0, 0);
    begin
      logic [N_CH-1:0] e;
      for (int c = 0; c < N_CH; c++) e[c] = mux_in[c*N_IN + c];
      check("f1_diag", 32'(mux_out), 32'(e));
    end

    // All selects 15 with valid toggling; old selects hold during load.
    cycle("f2_start", 1, 0, 0);
    for (int i = 0; i < 2*N_CH; i++) cycle("f2_word", 0, 1'(i % 2), 15);
    cycle("f2_commit", 0, 0, 0);
    check("f2_sel15", 32'(mux_out), 32'(route_all(15)));
    cycle("f2_after", 0, 0, 0);

    // Restart after 3 words, word in restart cycle discarded.
    cycle("f3_start", 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("f3_pre", 0, 1, 7);
    cycle("f3_restart", 1, 1, 9);
    for (int i = 0; i < N_CH; i++) cycle("f3_word", 0, 1, 5);
    cycle("f3_commit", 1, 0, 0);
    cycle("f3_after", 0, 0, 0);
    check("f3_err", 32'(cfg_err), 32'd1);
    check("f3_sel5", 32'(mux_out), 32'(route_all(5)));

    // Asynchronous reset mid-load.
    cycle("f4_start", 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("f4_word", 0, 1, 3);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    check("midrst_in0", 32'(mux_out), 32'(route_all(0)));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycle("f4_idle", 0, 0, 0);
    cycle("f4_idle2", 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cycle("rnd", 1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
